axis_governor_ctl: RTL and testbench

Stateful AXI Stream debug governor that sits inline on one stream, like the existing combinational governor, and adds command-driven run control. Supported modes are free-run, pause, step-N-flits and run-to-TLAST. Flits can be injected, dropped or copied to a log port. The log port is buffered, so `log_TVALID` never depends combinationally on `log_TREADY`. It is intended as the per-stream core of the debug controller FSM.

---
 rtl/axis_governor_ctl.sv | 174 +++++++++++++++++
 tb/tb_axis_governor_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_governor_ctl.sv
// Stateful AXI-Stream debug governor: inline run control (run/pause/step/run-to-last),
// flit injection, drop, and a 2-deep buffered log tap of accepted input flits.
module axis_governor_ctl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEST_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] in_TDATA,
    input  logic [DEST_WIDTH-1:0] in_TDEST,
    input  logic                  in_TLAST,
    input  logic                  in_TVALID,
    output logic                  in_TREADY,

    input  logic [DATA_WIDTH-1:0] inj_TDATA,
    input  logic [DEST_WIDTH-1:0] inj_TDEST,
    input  logic                  inj_TLAST,
    input  logic                  inj_TVALID,
    output logic                  inj_TREADY,

    output logic [DATA_WIDTH-1:0] out_TDATA,
    output logic [DEST_WIDTH-1:0] out_TDEST,
    output logic                  out_TLAST,
    output logic                  out_TVALID,
    input  logic                  out_TREADY,

    output logic [DATA_WIDTH-1:0] log_TDATA,
    output logic [DEST_WIDTH-1:0] log_TDEST,
    output logic                  log_TLAST,
    output logic                  log_TVALID,
    input  logic                  log_TREADY,

    input  logic                  cmd_valid,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_arg,

    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic                  drop_q,
    output logic                  log_en_q
);

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_PAUSED   = 2'd1,
        ST_STEPPING = 2'd2,
        ST_TO_LAST  = 2'd3
    } state_t;

    localparam logic [2:0] OP_RUN      = 3'd0;
    localparam logic [2:0] OP_PAUSE    = 3'd1;
    localparam logic [2:0] OP_STEP     = 3'd2;
    localparam logic [2:0] OP_TO_LAST  = 3'd3;
    localparam logic [2:0] OP_SET_MODE = 3'd4;
    localparam logic [2:0] OP_CLR_CNT  = 3'd5;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   remaining_q;

    logic [DATA_WIDTH-1:0]  log_data_q [2];
    logic [DEST_WIDTH-1:0]  log_dest_q [2];
    logic                   log_last_q [2];
    logic                   log_wr_ptr_q;
    logic                   log_rd_ptr_q;
    logic [1:0]             log_cnt_q;

    logic active;
    logic log_room;
    logic in_hs;
    logic log_push;
    logic log_pop;

    // Forward path and handshake qualification, all from registered control state.
    assign active     = (state_q != ST_PAUSED);
    assign log_room   = !log_en_q || (log_cnt_q < 2'd2);
    assign in_TREADY  = active && log_room && (drop_q || (!inj_TVALID && out_TREADY));
    assign out_TVALID = inj_TVALID || (in_TVALID && active && !drop_q && log_room);
    assign out_TDATA  = inj_TVALID ? inj_TDATA : in_TDATA;
    assign out_TDEST  = inj_TVALID ? inj_TDEST : in_TDEST;
    assign out_TLAST  = inj_TVALID ? inj_TLAST : in_TLAST;
    assign inj_TREADY = out_TREADY;

    assign in_hs    = in_TVALID && in_TREADY;
    assign log_push = in_hs && log_en_q;
    assign log_pop  = log_TVALID && log_TREADY;

    assign log_TVALID = (log_cnt_q != 2'd0);
    assign log_TDATA  = log_data_q[log_rd_ptr_q];
    assign log_TDEST  = log_dest_q[log_rd_ptr_q];
    assign log_TLAST  = log_last_q[log_rd_ptr_q];

    assign state = state_q;

    // Log FIFO storage; entries need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (log_push) begin
            log_data_q[log_wr_ptr_q] <= in_TDATA;
            log_dest_q[log_wr_ptr_q] <= in_TDEST;
            log_last_q[log_wr_ptr_q] <= in_TLAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_wr_ptr_q <= 1'b0;
            log_rd_ptr_q <= 1'b0;
            log_cnt_q    <= 2'd0;
        end else begin
            if (log_push) log_wr_ptr_q <= ~log_wr_ptr_q;
            if (log_pop)  log_rd_ptr_q <= ~log_rd_ptr_q;
            case ({log_push, log_pop})
                2'b10:   log_cnt_q <= log_cnt_q + 2'd1;
                2'b01:   log_cnt_q <= log_cnt_q - 2'd1;
                default: log_cnt_q <= log_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_count <= '0;
        end else if (cmd_valid && (cmd_op == OP_CLR_CNT)) begin
            flit_count <= '0;
        end else if (in_hs) begin
            flit_count <= flit_count + CNT_WIDTH'(1);
        end
    end

    // Run-control FSM: handshake transitions first, a same-cycle command overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUNNING;
            remaining_q <= '0;
            drop_q      <= 1'b0;
            log_en_q    <= 1'b0;
        end else begin
            if (in_hs) begin
                case (state_q)
                    ST_STEPPING: begin
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        if (remaining_q == CNT_WIDTH'(1)) state_q <= ST_PAUSED;
                    end
                    ST_TO_LAST: begin
                        if (in_TLAST) state_q <= ST_PAUSED;
                    end
                    default: ;
                endcase
            end
            if (cmd_valid) begin
                case (cmd_op)
                    OP_RUN:     state_q <= ST_RUNNING;
                    OP_PAUSE:   state_q <= ST_PAUSED;
                    OP_STEP: begin
                        if (cmd_arg != '0) begin
                            state_q     <= ST_STEPPING;
                            remaining_q <= cmd_arg;
                        end else begin
                            state_q <= ST_PAUSED;
                        end
                    end
                    OP_TO_LAST: state_q <= ST_TO_LAST;
                    OP_SET_MODE: begin
                        drop_q   <= cmd_arg[0];
                        log_en_q <= cmd_arg[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_governor_ctl.sv
// Directed self-checking bench for axis_governor_ctl.
module tb_axis_governor_ctl;

    localparam int unsigned DW = 64;
    localparam int unsigned TW = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_TDATA, inj_TDATA, out_TDATA, log_TDATA;
    logic [TW-1:0] in_TDEST, inj_TDEST, out_TDEST, log_TDEST;
    logic          in_TLAST, inj_TLAST, out_TLAST, log_TLAST;
    logic          in_TVALID, inj_TVALID, out_TVALID, log_TVALID;
    logic          in_TREADY, inj_TREADY, out_TREADY, log_TREADY;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_arg;
    logic [1:0]    state;
    logic [CW-1:0] flit_count;
    logic          drop_q, log_en_q;

    int checks = 0;
    int errors = 0;
    int acc;

    always #5 clk = ~clk;

    axis_governor_ctl #(.DATA_WIDTH(DW), .DEST_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_TDATA(in_TDATA), .in_TDEST(in_TDEST), .in_TLAST(in_TLAST),
        .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
        .inj_TDATA(inj_TDATA), .inj_TDEST(inj_TDEST), .inj_TLAST(inj_TLAST),
        .inj_TVALID(inj_TVALID), .inj_TREADY(inj_TREADY),
        .out_TDATA(out_TDATA), .out_TDEST(out_TDEST), .out_TLAST(out_TLAST),
        .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
        .log_TDATA(log_TDATA), .log_TDEST(log_TDEST), .log_TLAST(log_TLAST),
        .log_TVALID(log_TVALID), .log_TREADY(log_TREADY),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .state(state), .flit_count(flit_count), .drop_q(drop_q), .log_en_q(log_en_q)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [CW-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_TDATA = '0; in_TDEST = '0; in_TLAST = 1'b0; in_TVALID = 1'b0;
        inj_TDATA = '0; inj_TDEST = '0; inj_TLAST = 1'b0; inj_TVALID = 1'b0;
        out_TREADY = 1'b1; log_TREADY = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state: transparent passthrough
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(flit_count), 64'd0);
        check("rst_drop", 64'(drop_q), 64'd0);
        check("rst_log_en", 64'(log_en_q), 64'd0);
        check("rst_log_valid", 64'(log_TVALID), 64'd0);
        check("rst_in_ready", 64'(in_TREADY), 64'd1);

        // Passthrough of 0x1..0x4
        for (int i = 1; i <= 4; i++) begin
            in_TVALID = 1'b1;
            in_TDATA  = 64'(i);
            #1;
            check("pass_data", out_TDATA, 64'(i));
            check("pass_valid", 64'(out_TVALID), 64'd1);
            check("pass_ready", 64'(in_TREADY), 64'd1);
            check("pass_no_log", 64'(log_TVALID), 64'd0);
            step();
        end
        in_TVALID = 1'b0;
        #1;
        check("pass_count", 64'(flit_count), 64'd4);
        check("pass_no_log_end", 64'(log_TVALID), 64'd0);

        // Step 3 out of 10 queued flits
        do_cmd(3'd1, '0);
        check("pause_state", 64'(state), 64'd1);
        do_cmd(3'd5, '0);
        check("clr_count", 64'(flit_count), 64'd0);
        in_TVALID = 1'b1;
        in_TDATA  = 64'h10;
        #1;
        check("paused_not_ready", 64'(in_TREADY), 64'd0);
        do_cmd(3'd2, 16'd3);
        check("step_state", 64'(state), 64'd2);
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            in_TDATA = 64'(16 + acc);
            #1;
            if (in_TREADY) acc++;
            step();
        end
        check("step_accepted", 64'(acc), 64'd3);
        check("step_end_state", 64'(state), 64'd1);
        check("step_end_ready", 64'(in_TREADY), 64'd0);
        check("step_count", 64'(flit_count), 64'd3);

        // Run to TLAST on a 5-flit packet with more flits queued
        do_cmd(3'd3, '0);
        check("to_last_state", 64'(state), 64'd3);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            in_TDATA = 64'(32 + acc);
            in_TLAST = (acc == 4);
            #1;
            if (in_TREADY) begin
                check("to_last_data", out_TDATA, 64'(32 + acc));
                acc++;
            end
            step();
        end
        in_TLAST = 1'b0;
        check("to_last_accepted", 64'(acc), 64'd5);
        check("to_last_end_state", 64'(state), 64'd1);
        check("to_last_count", 64'(flit_count), 64'd8);

        // Drop + log with log backpressure
        in_TVALID = 1'b0;
        do_cmd(3'd0, '0);
        do_cmd(3'd4, 16'd3);
        check("mode_drop", 64'(drop_q), 64'd1);
        check("mode_log", 64'(log_en_q), 64'd1);
        log_TREADY = 1'b0;
        in_TVALID  = 1'b1;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_TDATA = 64'(256 + acc);
            #1;
            check("drop_out_invalid", 64'(out_TVALID), 64'd0);
            if (in_TREADY) acc++;
            step();
        end
        check("drop_log_accepted", 64'(acc), 64'd2);
        check("drop_log_full_ready", 64'(in_TREADY), 64'd0);
        check("drop_log_valid", 64'(log_TVALID), 64'd1);
        check("drop_log_head", log_TDATA, 64'h100);
        log_TREADY = 1'b1;
        in_TDATA   = 64'h102;
        #1;
        check("drain_head0", log_TDATA, 64'h100);
        check("drain_no_free_slot", 64'(in_TREADY), 64'd0);
        step();
        check("drain_head1", log_TDATA, 64'h101);
        check("drain_resume", 64'(in_TREADY), 64'd1);
        step();
        in_TVALID = 1'b0;
        #1;
        check("drain_head2", log_TDATA, 64'h102);
        step();
        check("drain_empty", 64'(log_TVALID), 64'd0);
        check("drain_count", 64'(flit_count), 64'd11);

        // Inject while paused
        do_cmd(3'd4, 16'd0);
        do_cmd(3'd1, '0);
        in_TVALID  = 1'b1;
        in_TDATA   = 64'h55;
        inj_TVALID = 1'b1;
        inj_TDATA  = 64'hAA;
        #1;
        check("inj_data", out_TDATA, 64'hAA);
        check("inj_valid", 64'(out_TVALID), 64'd1);
        check("inj_ready_hi", 64'(inj_TREADY), 64'd1);
        check("inj_in_blocked", 64'(in_TREADY), 64'd0);
        out_TREADY = 1'b0;
        #1;
        check("inj_ready_lo", 64'(inj_TREADY), 64'd0);
        step();
        out_TREADY = 1'b1;
        step();
        inj_TVALID = 1'b0;
        in_TVALID  = 1'b0;
        #1;
        check("inj_count_unchanged", 64'(flit_count), 64'd11);

        // CLR_CNT wins over a same-cycle handshake
        do_cmd(3'd0, '0);
        in_TVALID = 1'b1;
        in_TDATA  = 64'h77;
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        #1;
        check("clr_hs_ready", 64'(in_TREADY), 64'd1);
        step();
        cmd_valid = 1'b0;
        check("clr_wins", 64'(flit_count), 64'd0);
        step();
        in_TVALID = 1'b0;
        check("count_after_clr", 64'(flit_count), 64'd1);

        // Full throughput with log enabled
        do_cmd(3'd4, 16'd2);
        in_TVALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_TDATA = 64'(512 + k);
            #1;
            check("tput_ready", 64'(in_TREADY), 64'd1);
            if (k > 0) check("tput_log_data", log_TDATA, 64'(511 + k));
            step();
        end
        in_TVALID = 1'b0;
        #1;
        check("tput_log_last", log_TDATA, 64'h203);
        step();
        check("tput_log_empty", 64'(log_TVALID), 64'd0);

        // Reset with log buffer full
        log_TREADY = 1'b0;
        in_TVALID  = 1'b1;
        in_TDATA   = 64'h300;
        step();
        in_TDATA   = 64'h301;
        step();
        check("full_not_ready", 64'(in_TREADY), 64'd0);
        check("full_log_valid", 64'(log_TVALID), 64'd1);
        in_TVALID = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_log_valid", 64'(log_TVALID), 64'd0);
        check("rst_mid_state", 64'(state), 64'd0);
        check("rst_mid_log_en", 64'(log_en_q), 64'd0);
        check("rst_mid_count", 64'(flit_count), 64'd0);

        // Counter wrap-around
        log_TREADY = 1'b1;
        in_TVALID  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_max", 64'(flit_count), 64'hFFFF);
        step();
        check("wrap_zero", 64'(flit_count), 64'd0);
        in_TVALID = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
